// File: rtl/phy_rx_pkg.sv
// Shared definitions for the two-lane PHY receive start-up logic.
//   COM_SYM_DEF  : default training/alignment symbol (K28.5 byte, 8'hBC)
//   lane_state_t : per-lane symbol-lock states
//   top_state_t  : lane-pair sequencing states
package phy_rx_pkg;

   localparam logic [7:0] COM_SYM_DEF = 8'hBC;

   typedef enum logic [1:0] {
      LANE_HUNT,
      LANE_COUNT,
      LANE_LOCKED
   } lane_state_t;

   typedef enum logic [1:0] {
      TOP_IDLE,
      TOP_WAIT_LOCK,
      TOP_ALIGN,
      TOP_ACTIVE
   } top_state_t;

endpackage

// File: rtl/rx_lane_lock.sv
// Per-lane symbol lock tracker.
// It hunts for COM_SYM and declares lock after LOCK_COUNT consecutive valid COM
// bytes. Lock is dropped after LOSS_COUNT consecutive invalid cycles.
// Ports:
//   clk_4f      : byte clock
//   reset       : asynchronous, active-low
//   clear       : synchronous force to HUNT with counters cleared
//   data, valid : lane byte stream
//   locked      : registered lock status
//   next_locked : lock status that will be registered on the coming edge
module rx_lane_lock
   import phy_rx_pkg::*;
#(
   parameter logic [7:0]  COM_SYM    = COM_SYM_DEF,
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned LOSS_COUNT = 4
) (
   input  logic       clk_4f,
   input  logic       reset,
   input  logic       clear,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       locked,
   output logic       next_locked
);

   localparam logic [3:0] LOCK_LIM = 4'(LOCK_COUNT);
   localparam logic [3:0] LOSS_LIM = 4'(LOSS_COUNT);

   lane_state_t state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  loss_q, loss_d;
   logic        is_com;

   assign is_com = valid && (data == COM_SYM);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      loss_d  = loss_q;
      if (clear) begin
         state_d = LANE_HUNT;
         cnt_d   = '0;
         loss_d  = '0;
      end else begin
         case (state_q)
            LANE_HUNT: begin
               if (is_com) begin
                  state_d = LANE_COUNT;
                  cnt_d   = 4'd1;
               end
            end
            LANE_COUNT: begin
               if (is_com) begin
                  if (cnt_q + 4'd1 == LOCK_LIM) begin
                     state_d = LANE_LOCKED;
                     cnt_d   = '0;
                     loss_d  = '0;
                  end else if (cnt_q != '1) begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end else if (valid) begin
                  state_d = LANE_HUNT;
                  cnt_d   = '0;
               end
            end
            LANE_LOCKED: begin
               // Any valid byte (COM or payload) counts as link activity.
               if (valid) begin
                  loss_d = '0;
               end else if (loss_q + 4'd1 == LOSS_LIM) begin
                  state_d = LANE_HUNT;
                  cnt_d   = '0;
                  loss_d  = '0;
               end else if (loss_q != '1) begin
                  loss_d = loss_q + 4'd1;
               end
            end
            default: begin
               state_d = LANE_HUNT;
               cnt_d   = '0;
               loss_d  = '0;
            end
         endcase
      end
   end

   assign next_locked = (state_d == LANE_LOCKED);

   always_ff @(posedge clk_4f or negedge reset) begin
      if (!reset) begin
         state_q <= LANE_HUNT;
         cnt_q   <= '0;
         loss_q  <= '0;
         locked  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         loss_q  <= loss_d;
         locked  <= next_locked;
      end
   end

endmodule

// File: rtl/rx_lane_sync_ctrl.sv
// Two-lane receive start-up sequencer.
// It waits for both lanes to lock, then for a common COM boundary, and then
// raises sincronizar_bus (the sync input of the lane-0 m8_32 converter).
// Ports:
//   clk_4f          : byte clock
//   reset           : asynchronous, active-low
//   sync_en         : acquisition enable (low forces IDLE)
//   data_in_0/1     : lane bytes from serial_paralelo
//   valid_in_0/1    : lane byte valids
//   sincronizar_bus : high while ACTIVE
//   lane_lock       : per-lane lock status
//   align_err       : one-cycle pulse on ALIGN timeout
//   active          : high while ACTIVE
module rx_lane_sync_ctrl
   import phy_rx_pkg::*;
#(
   parameter logic [7:0]  COM_SYM       = COM_SYM_DEF,
   parameter int unsigned LOCK_COUNT    = 4,
   parameter int unsigned LOSS_COUNT    = 4,
   parameter int unsigned ALIGN_TIMEOUT = 16
) (
   input  logic       clk_4f,
   input  logic       reset,
   input  logic       sync_en,
   input  logic [7:0] data_in_0,
   input  logic       valid_in_0,
   input  logic [7:0] data_in_1,
   input  logic       valid_in_1,
   output logic       sincronizar_bus,
   output logic [1:0] lane_lock,
   output logic       align_err,
   output logic       active
);

   localparam logic [7:0] TMO_LIM = 8'(ALIGN_TIMEOUT);

   top_state_t state_q, state_d;
   logic [7:0] tmr_q, tmr_d;
   logic       sync_q, err_q, err_d;
   logic [1:0] next_lock;
   logic       lane_clear;
   logic       both_locked, common_com;

   // The top next state is IDLE exactly when sync_en is low. Clearing the
   // lanes on sync_en therefore matches "forced to HUNT in IDLE" without a
   // combinational loop through the top next-state logic.
   assign lane_clear = ~sync_en;

   rx_lane_lock #(
      .COM_SYM    (COM_SYM),
      .LOCK_COUNT (LOCK_COUNT),
      .LOSS_COUNT (LOSS_COUNT)
   ) u_lane0 (
      .clk_4f      (clk_4f),
      .reset       (reset),
      .clear       (lane_clear),
      .data        (data_in_0),
      .valid       (valid_in_0),
      .locked      (lane_lock[0]),
      .next_locked (next_lock[0])
   );

   rx_lane_lock #(
      .COM_SYM    (COM_SYM),
      .LOCK_COUNT (LOCK_COUNT),
      .LOSS_COUNT (LOSS_COUNT)
   ) u_lane1 (
      .clk_4f      (clk_4f),
      .reset       (reset),
      .clear       (lane_clear),
      .data        (data_in_1),
      .valid       (valid_in_1),
      .locked      (lane_lock[1]),
      .next_locked (next_lock[1])
   );

   assign both_locked = &next_lock;
   assign common_com  = valid_in_0 && valid_in_1 &&
                        (data_in_0 == COM_SYM) && (data_in_1 == COM_SYM);

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      err_d   = 1'b0;
      if (!sync_en) begin
         state_d = TOP_IDLE;
         tmr_d   = '0;
      end else begin
         case (state_q)
            TOP_IDLE: state_d = TOP_WAIT_LOCK;
            TOP_WAIT_LOCK: begin
               if (both_locked) begin
                  state_d = TOP_ALIGN;
                  tmr_d   = '0;
               end
            end
            TOP_ALIGN: begin
               // Lock loss beats alignment. Alignment beats timeout.
               if (!both_locked) begin
                  state_d = TOP_WAIT_LOCK;
               end else if (common_com) begin
                  state_d = TOP_ACTIVE;
               end else if (tmr_q + 8'd1 == TMO_LIM) begin
                  state_d = TOP_WAIT_LOCK;
                  tmr_d   = '0;
                  err_d   = 1'b1;
               end else if (tmr_q != '1) begin
                  tmr_d = tmr_q + 8'd1;
               end
            end
            TOP_ACTIVE: begin
               if (!both_locked) state_d = TOP_WAIT_LOCK;
            end
            default: state_d = TOP_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_4f or negedge reset) begin
      if (!reset) begin
         state_q <= TOP_IDLE;
         tmr_q   <= '0;
         sync_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         sync_q  <= (state_d == TOP_ACTIVE);
         err_q   <= err_d;
      end
   end

   assign sincronizar_bus = sync_q;
   assign active          = sync_q;
   assign align_err       = err_q;

endmodule

// File: tb/tb_rx_lane_sync_ctrl.sv
module tb_rx_lane_sync_ctrl;

   localparam logic [7:0]  COM = 8'hBC;
   localparam logic [7:0]  PAY = 8'h00;
   localparam int unsigned LOCK_N = 4;
   localparam int unsigned LOSS_N = 4;
   localparam int unsigned TMO_N  = 16;

   logic       clk_4f = 1'b0;
   logic       reset = 1'b0;
   logic       sync_en = 1'b0;
   logic [7:0] data_in_0 = '0, data_in_1 = '0;
   logic       valid_in_0 = 1'b0, valid_in_1 = 1'b0;
   logic       sincronizar_bus, align_err, active;
   logic [1:0] lane_lock;

   int checks = 0;
   int errors = 0;

   rx_lane_sync_ctrl #(
      .COM_SYM       (COM),
      .LOCK_COUNT    (LOCK_N),
      .LOSS_COUNT    (LOSS_N),
      .ALIGN_TIMEOUT (TMO_N)
   ) dut (
      .clk_4f          (clk_4f),
      .reset           (reset),
      .sync_en         (sync_en),
      .data_in_0       (data_in_0),
      .valid_in_0      (valid_in_0),
      .data_in_1       (data_in_1),
      .valid_in_1      (valid_in_1),
      .sincronizar_bus (sincronizar_bus),
      .lane_lock       (lane_lock),
      .align_err       (align_err),
      .active          (active)
   );

   always #5 clk_4f = ~clk_4f;

   // Reference model: run lengths per lane and a coarse mode number
   // (0 idle, 1 waiting for lock, 2 aligning, 3 synced).
   int m_run[2];
   int m_miss[2];
   bit m_lk[2];
   int m_mode, m_tmr;
   bit m_sync, m_err;

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_run[i] = 0; m_miss[i] = 0; m_lk[i] = 0;
      end
      m_mode = 0; m_tmr = 0; m_sync = 0; m_err = 0;
   endfunction

   function automatic void lane_model(int i, bit v, logic [7:0] d);
      if (!m_lk[i]) begin
         if (v) m_run[i] = (d == COM) ? m_run[i] + 1 : 0;
         if (m_run[i] >= int'(LOCK_N)) begin
            m_lk[i] = 1; m_run[i] = 0; m_miss[i] = 0;
         end
      end else begin
         m_miss[i] = v ? 0 : m_miss[i] + 1;
         if (m_miss[i] >= int'(LOSS_N)) begin
            m_lk[i] = 0; m_run[i] = 0; m_miss[i] = 0;
         end
      end
   endfunction

   function automatic void model_step(bit se, bit v0, logic [7:0] d0, bit v1, logic [7:0] d1);
      bit both, common;
      m_err = 0;
      if (!se) begin
         for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_miss[i] = 0; m_lk[i] = 0;
         end
         m_mode = 0;
      end else begin
         lane_model(0, v0, d0);
         lane_model(1, v1, d1);
         both   = m_lk[0] && m_lk[1];
         common = v0 && v1 && d0 == COM && d1 == COM;
         if (m_mode == 0) m_mode = 1;
         else if (m_mode == 1) begin
            if (both) begin m_mode = 2; m_tmr = 0; end
         end else if (m_mode == 2) begin
            if (!both) m_mode = 1;
            else if (common) m_mode = 3;
            else begin
               m_tmr++;
               if (m_tmr >= int'(TMO_N)) begin m_mode = 1; m_err = 1; end
            end
         end else if (!both) m_mode = 1;
      end
      m_sync = (m_mode == 3);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle from a falling edge, step the model at the rising edge,
   // and compare at the next falling edge.
   task automatic cyc(input bit se, input bit v0, input logic [7:0] d0,
                      input bit v1, input logic [7:0] d1);
      sync_en = se; valid_in_0 = v0; data_in_0 = d0; valid_in_1 = v1; data_in_1 = d1;
      @(posedge clk_4f);
      model_step(se, v0, d0, v1, d1);
      @(negedge clk_4f);
      chk("model_sync", int'(sincronizar_bus), int'(m_sync));
      chk("model_active", int'(active), int'(m_sync));
      chk("model_lock", int'(lane_lock), int'({m_lk[1], m_lk[0]}));
      chk("model_err", int'(align_err), int'(m_err));
   endtask

   task automatic lock_both();
      cyc(0, 1, COM, 1, COM);
      for (int i = 0; i < 4; i++) cyc(1, 1, COM, 1, COM);
      chk("lock_both", int'(lane_lock), 3);
   endtask

   typedef struct {
      bit         se, v0;
      logic [7:0] d0;
      bit         v1;
      logic [7:0] d1;
      bit         e_sync;
      logic [1:0] e_lock;
      bit         e_err;
   } vec_t;

   function automatic vec_t mkv(bit se, bit e_sync, logic [1:0] e_lock);
      vec_t v;
      v.se = se; v.v0 = 1; v.d0 = COM; v.v1 = 1; v.d1 = COM;
      v.e_sync = e_sync; v.e_lock = e_lock; v.e_err = 0;
      return v;
   endfunction

   vec_t tbl[7];

   initial begin
      bit v0, v1, c0, c1, se;
      logic [7:0] d0, d1;

      tbl[0] = mkv(0, 0, 2'b00);
      tbl[1] = mkv(0, 0, 2'b00);
      tbl[2] = mkv(1, 0, 2'b00);
      tbl[3] = mkv(1, 0, 2'b00);
      tbl[4] = mkv(1, 0, 2'b00);
      tbl[5] = mkv(1, 0, 2'b11);
      tbl[6] = mkv(1, 1, 2'b11);

      model_reset();
      #1;
      chk("reset_sync", int'(sincronizar_bus), 0);
      chk("reset_lock", int'(lane_lock), 0);
      chk("reset_err", int'(align_err), 0);
      @(negedge clk_4f);
      reset = 1'b1;

      // Enable sequence from a table.
      foreach (tbl[i]) begin
         cyc(tbl[i].se, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1);
         chk($sformatf("tbl%0d_sync", i), int'(sincronizar_bus), int'(tbl[i].e_sync));
         chk($sformatf("tbl%0d_lock", i), int'(lane_lock), int'(tbl[i].e_lock));
         chk($sformatf("tbl%0d_err", i), int'(align_err), int'(tbl[i].e_err));
      end

      // Lock loss: three invalid cycles are tolerated, the fourth drops lock.
      for (int i = 0; i < 3; i++) cyc(1, 1, COM, 0, COM);
      cyc(1, 1, COM, 1, PAY);
      chk("loss3_sync", int'(sincronizar_bus), 1);
      chk("loss3_lock", int'(lane_lock), 3);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 1, COM, 0, COM);
         chk($sformatf("loss4_sync%0d", i), int'(sincronizar_bus), (i == 3) ? 0 : 1);
         chk($sformatf("loss4_lock%0d", i), int'(lane_lock), (i == 3) ? 1 : 3);
      end

      // Broken training on lane 0.
      cyc(0, 0, PAY, 0, PAY);
      begin
         logic [7:0] seq [8];
         seq = '{COM, COM, COM, PAY, COM, COM, COM, COM};
         for (int i = 0; i < 8; i++) begin
            cyc(1, 1, seq[i], 0, PAY);
            chk($sformatf("broken_lock%0d", i), int'(lane_lock[0]), (i == 7) ? 1 : 0);
         end
      end

      // Skewed lanes time out once, then realign.
      lock_both();
      for (int k = 0; k < 16; k++) begin
         cyc(1, 1, (k % 2 == 0) ? COM : PAY, 1, (k % 2 == 0) ? PAY : COM);
         chk($sformatf("skew_err%0d", k), int'(align_err), (k == 15) ? 1 : 0);
         chk($sformatf("skew_sync%0d", k), int'(sincronizar_bus), 0);
      end
      cyc(1, 1, COM, 1, PAY);
      chk("skew_err_once", int'(align_err), 0);
      cyc(1, 1, COM, 1, COM);
      chk("realign_sync", int'(sincronizar_bus), 1);

      // Common COM on the timeout cycle: alignment wins.
      lock_both();
      for (int k = 0; k < 15; k++) cyc(1, 1, COM, 1, PAY);
      cyc(1, 1, COM, 1, COM);
      chk("tmo_vs_com_sync", int'(sincronizar_bus), 1);
      chk("tmo_vs_com_err", int'(align_err), 0);

      // sync_en low beats alignment.
      lock_both();
      cyc(0, 1, COM, 1, COM);
      chk("en_prio_sync", int'(sincronizar_bus), 0);
      chk("en_prio_lock", int'(lane_lock), 0);

      // Async reset while ACTIVE.
      lock_both();
      cyc(1, 1, COM, 1, COM);
      chk("pre_rst_sync", int'(sincronizar_bus), 1);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_sync", int'(sincronizar_bus), 0);
      chk("async_rst_active", int'(active), 0);
      chk("async_rst_lock", int'(lane_lock), 0);
      model_reset();
      @(negedge clk_4f);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) cyc(1, 1, COM, 1, COM);
      chk("post_rst_sync", int'(sincronizar_bus), 1);

      // Randomised traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         se = ($urandom_range(0, 149) != 0);
         v0 = ($urandom_range(0, 11) != 0);
         v1 = ($urandom_range(0, 11) != 0);
         c0 = ($urandom_range(0, 9) < 7);
         c1 = ($urandom_range(0, 9) < 8) ? c0 : !c0;
         d0 = c0 ? COM : 8'($urandom_range(0, 255));
         d1 = c1 ? COM : 8'($urandom_range(0, 255));
         cyc(se, v0, d0, v1, d1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
